// File: rtl/max7219_rx.sv
// Receive-side MAX7219 model. It assembles 16-bit SCK/CS/DIN frames into a register file and drives a segment view.
// Define MAX7219_RX_CODEB_EN to enable Code-B font decoding of digits on seg_out.
module max7219_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        cs,
    input  logic        din,
    output logic        dout,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic [63:0] seg_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    logic [2:0]       sck_sync_q;
    logic [2:0]       cs_sync_q;
    logic [1:0]       din_sync_q;
    logic             sck_rise, sck_fall, cs_rise, cs_fall, din_s;

    state_t           state_q;
    logic [4:0]       bit_cnt_q;
    logic [15:0]      sr_q;
    logic             dout_q;
    logic             wr_stb_q;
    logic             frame_err_q;
    logic [3:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [7:0][7:0]  digits_q;
    logic [7:0]       decode_q;
    logic [3:0]       intensity_q;
    logic [2:0]       scan_limit_q;
    logic             shutdown_n_q;
    logic             display_test_q;
    logic [7:0][7:0]  seg_d;

    // NOTE: the synchronizer chains carry no reset, so a CS held low across reset creates no false edge.
    always_ff @(posedge clk) begin
        sck_sync_q <= {sck_sync_q[1:0], sck};
        cs_sync_q  <= {cs_sync_q[1:0], cs};
        din_sync_q <= {din_sync_q[0], din};
    end

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign din_s    = din_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            sr_q           <= '0;
            dout_q         <= 1'b0;
            wr_stb_q       <= 1'b0;
            frame_err_q    <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            digits_q       <= '0;
            decode_q       <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
        end else begin
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    bit_cnt_q <= '0;
                end
                S_SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt_q == 5'd16) begin
                            state_q <= S_LATCH;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end else begin
                        if (sck_rise) begin
                            sr_q <= {sr_q[14:0], din_s};
                            if (bit_cnt_q != 5'd16) bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                        if (sck_fall) dout_q <= sr_q[15];
                    end
                end
                S_LATCH: begin
                    wr_stb_q  <= 1'b1;
                    wr_addr_q <= sr_q[11:8];
                    wr_data_q <= sr_q[7:0];
                    case (sr_q[11:8])
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digits_q[sr_q[10:8] - 3'd1] <= sr_q[7:0];
                        4'h9: decode_q       <= sr_q[7:0];
                        4'hA: intensity_q    <= sr_q[3:0];
                        4'hB: scan_limit_q   <= sr_q[2:0];
                        4'hC: shutdown_n_q   <= sr_q[0];
                        4'hF: display_test_q <= sr_q[0];
                        default: ;
                    endcase
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // A new chip-select always starts a fresh frame, whatever was in progress.
            if (cs_fall) begin
                state_q   <= S_SHIFT;
                bit_cnt_q <= '0;
            end
        end
    end

`ifdef MAX7219_RX_CODEB_EN
    function automatic logic [6:0] codeb(input logic [3:0] v);
        case (v)
            4'h0: codeb = 7'h7E;
            4'h1: codeb = 7'h30;
            4'h2: codeb = 7'h6D;
            4'h3: codeb = 7'h79;
            4'h4: codeb = 7'h33;
            4'h5: codeb = 7'h5B;
            4'h6: codeb = 7'h5F;
            4'h7: codeb = 7'h70;
            4'h8: codeb = 7'h7F;
            4'h9: codeb = 7'h7B;
            4'hA: codeb = 7'h01;
            4'hB: codeb = 7'h4F;
            4'hC: codeb = 7'h37;
            4'hD: codeb = 7'h0E;
            4'hE: codeb = 7'h67;
            default: codeb = 7'h00;
        endcase
    endfunction
`endif

    // NOTE: seg_d gets a full default before the loop, so no path leaves it unassigned.
    always_comb begin
        seg_d = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (display_test_q) begin
                seg_d[n] = 8'hFF;
            end else if (!shutdown_n_q || n > 32'(scan_limit_q)) begin
                seg_d[n] = 8'h00;
            end else begin
`ifdef MAX7219_RX_CODEB_EN
                if (decode_q[n]) seg_d[n] = {digits_q[n][7], codeb(digits_q[n][3:0])};
                else             seg_d[n] = digits_q[n];
`else
                seg_d[n] = digits_q[n];
`endif
            end
        end
    end

    assign dout         = dout_q;
    assign wr_stb       = wr_stb_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_err    = frame_err_q;
    assign digits       = digits_q;
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_limit_q;
    assign shutdown_n   = shutdown_n_q;
    assign display_test = display_test_q;
    assign seg_out      = seg_d;

endmodule
